// File: rtl/fft_out_reorder.sv
// fft_out_reorder: collects bit-reversed 4-lane FFT beats into a ping-pong frame buffer
// and streams each completed frame out one sample per handshake in natural bin order.
module fft_out_reorder #(
    parameter int NBITS_out = 10,
    parameter int N         = 128,
    parameter int LOG2N     = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic                   in_sof,
    input  logic [2*NBITS_out-1:0] fftOut0_up,
    input  logic [2*NBITS_out-1:0] fftOut0_down,
    input  logic [2*NBITS_out-1:0] fftOut1_up,
    input  logic [2*NBITS_out-1:0] fftOut1_down,
    output logic [2*NBITS_out-1:0] out_data,
    output logic [LOG2N-1:0]       out_index,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   frame_drop,
    output logic                   sync_err
);
    localparam int W  = 2*NBITS_out;
    localparam int BW = LOG2N-2;
    localparam logic [BW-1:0] LAST_BEAT = '1;

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wstate_t;

    wstate_t          state_q, state_d;
    logic [BW-1:0]    b_q, b_d, wr_beat;
    logic [1:0]       full_q, full_d;
    logic             wr_bank_q, rd_bank_q;
    logic [LOG2N-1:0] rd_idx_q;
    logic             we, set_full, drop_d, serr_d, drop_q, serr_q, hs, rd_done;
    logic [W-1:0]     mem_q [2][N];
    logic [W-1:0]     lane [4];

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
        return r;
    endfunction

    assign lane[0] = fftOut0_up;
    assign lane[1] = fftOut0_down;
    assign lane[2] = fftOut1_up;
    assign lane[3] = fftOut1_down;
    // an sof beat always lands as beat 0, including a resync inside W_FILL
    assign wr_beat = in_sof ? '0 : b_q;

    always_comb begin
        state_d  = state_q;
        b_d      = b_q;
        we       = 1'b0;
        set_full = 1'b0;
        drop_d   = 1'b0;
        serr_d   = 1'b0;
        if (in_valid) begin
            case (state_q)
                W_IDLE: if (in_sof) begin
                    b_d     = BW'(1);
                    drop_d  = full_q[wr_bank_q];
                    we      = !full_q[wr_bank_q];
                    state_d = full_q[wr_bank_q] ? W_DROP : W_FILL;
                end
                W_FILL: begin
                    we = 1'b1;
                    if (in_sof) begin
                        serr_d = 1'b1;
                        b_d    = BW'(1);
                    end else if (b_q == LAST_BEAT) begin
                        set_full = 1'b1;
                        b_d      = '0;
                        state_d  = W_IDLE;
                    end else b_d = b_q + 1'b1;
                end
                W_DROP: if (in_sof) begin
                    serr_d = 1'b1;
                    b_d    = BW'(1);
                end else if (b_q == LAST_BEAT) begin
                    b_d     = '0;
                    state_d = W_IDLE;
                end else b_d = b_q + 1'b1;
                default: state_d = W_IDLE;
            endcase
        end
    end

    assign hs      = full_q[rd_bank_q] & out_ready;
    assign rd_done = hs & (rd_idx_q == '1);

    // writer and reader touch different banks, so both updates may land on one edge
    always_comb begin
        full_d = full_q;
        if (set_full) full_d[wr_bank_q] = 1'b1;
        if (rd_done) full_d[rd_bank_q] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= W_IDLE;
            b_q       <= '0;
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            rd_idx_q  <= '0;
            drop_q    <= 1'b0;
            serr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            b_q       <= b_d;
            full_q    <= full_d;
            wr_bank_q <= wr_bank_q ^ set_full;
            rd_bank_q <= rd_bank_q ^ rd_done;
            rd_idx_q  <= rd_idx_q + LOG2N'(hs);
            drop_q    <= drop_d;
            serr_q    <= serr_d;
        end
    end

    always_ff @(posedge clk)
        if (we) for (int l = 0; l < 4; l++) mem_q[wr_bank_q][bitrev({wr_beat, 2'(l)})] <= lane[l];

    assign out_valid  = full_q[rd_bank_q];
    assign out_data   = mem_q[rd_bank_q][rd_idx_q];
    assign out_index  = rd_idx_q;
    assign out_last   = out_valid & (rd_idx_q == '1);
    assign frame_drop = drop_q;
    assign sync_err   = serr_q;
endmodule

// File: tb/tb_fft_out_reorder.sv
// tb_fft_out_reorder: random-data frames checked against a natural-order reference built
// from the bit-reversed input positions, with back-pressure, overflow, resync and reset cases.
module tb_fft_out_reorder;
    localparam int NB = 10;
    localparam int W  = 2*NB;
    localparam int N  = 128;
    localparam int LG = 7;

    logic clk = 1'b0;
    logic rst, in_valid, in_sof, out_ready, out_valid, out_last, frame_drop, sync_err;
    logic [W-1:0]  l0, l1, l2, l3, out_data;
    logic [LG-1:0] out_index;

    fft_out_reorder #(.NBITS_out(NB), .N(N), .LOG2N(LG)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
        .fftOut0_up(l0), .fftOut0_down(l1), .fftOut1_up(l2), .fftOut1_down(l3),
        .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .frame_drop(frame_drop), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int hs = 0, drops = 0, serrs = 0, gaps = 0;
    int ready_mode = 1;
    bit t1 = 0, track_gap = 0, stall_q = 0;
    logic [W-1:0]  hold_d;
    logic [LG-1:0] hold_i;
    logic [W-1:0]  frames [3][N];
    logic [W-1:0]  exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int rev(input int k);
        int r = 0;
        for (int j = 0; j < LG; j++) r = (r << 1) | ((k >> j) & 1);
        return r;
    endfunction

    // natural bin k holds the input element whose arrival position is bitrev(k)
    task automatic expect_frame(input int sel);
        for (int k = 0; k < N; k++) exp_q.push_back(frames[sel][rev(k)]);
    endtask

    task automatic fill(input int sel, input bit rnd);
        for (int i = 0; i < N; i++)
            frames[sel][i] = rnd ? {NB'($urandom_range(0, 823)), NB'($urandom)} : {NB'(i), NB'(0)};
    endtask

    task automatic drive_beat(input int sel, input int b, input bit sof);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_sof   = sof;
        l0 = frames[sel][4*b];
        l1 = frames[sel][4*b+1];
        l2 = frames[sel][4*b+2];
        l3 = frames[sel][4*b+3];
    endtask

    task automatic send_frame(input int sel, input int nbeats);
        for (int b = 0; b < nbeats; b++) drive_beat(sel, b, b == 0);
    endtask

    task automatic idle;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() > 0 || out_valid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", n < budget, 1);
    endtask

    always @(posedge clk) begin
        #1;
        out_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
    end

    always @(negedge clk) begin
        if (rst) stall_q = 0;
        else begin
            if (frame_drop) drops++;
            if (sync_err) serrs++;
            if (stall_q && out_valid) begin
                chk("hold_data", out_data, hold_d);
                chk("hold_idx", out_index, hold_i);
            end
            if (track_gap && !out_valid && exp_q.size() > 0 && exp_q.size() < 2*N) gaps++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("extra_out", 1, 0);
                else begin
                    chk("data", out_data, exp_q[0]);
                    chk("index", out_index, hs % N);
                    chk("last", out_last, (hs % N) == N-1);
                    if (t1 && (out_index == 0 || out_index == 1 || out_index == 2 || out_index == 127))
                        chk("t1_real", out_data[W-1:NB], rev(int'(out_index)));
                    void'(exp_q.pop_front());
                end
                hs++;
            end else if (!out_valid) chk("last_idle", out_last, 0);
            stall_q = out_valid && !out_ready;
            hold_d  = out_data;
            hold_i  = out_index;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int h0, d0, s0, n;
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0;
        l0 = '0; l1 = '0; l2 = '0; l3 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_index", out_index, 0);
        chk("rst_drop", frame_drop, 0);
        chk("rst_serr", sync_err, 0);

        // single frame, ramp data, ready high, latency check
        fill(0, 0);
        expect_frame(0);
        h0 = hs; t1 = 1;
        send_frame(0, N/4);
        @(negedge clk) chk("pre_valid", out_valid, 0);
        idle;
        @(negedge clk) chk("latency", out_valid, 1);
        wait_drain(1000);
        t1 = 0;
        chk("t1_count", hs - h0, N);

        // same frame under random back-pressure
        ready_mode = 2;
        expect_frame(0);
        h0 = hs;
        send_frame(0, N/4);
        idle;
        wait_drain(3000);
        chk("t2_count", hs - h0, N);

        // ping-pong: two frames back-to-back, B = A + 200 on real
        ready_mode = 1;
        fill(0, 1);
        for (int i = 0; i < N; i++) frames[1][i] = frames[0][i] + {NB'(200), NB'(0)};
        expect_frame(0);
        expect_frame(1);
        h0 = hs; d0 = drops; gaps = 0; track_gap = 1;
        send_frame(0, N/4);
        send_frame(1, N/4);
        idle;
        wait_drain(2000);
        track_gap = 0;
        chk("t3_count", hs - h0, 2*N);
        chk("t3_gaps", gaps, 0);
        chk("t3_drops", drops - d0, 0);

        // overflow: three frames with ready low, third is dropped
        ready_mode = 0;
        fill(0, 1); fill(1, 1); fill(2, 1);
        expect_frame(0);
        expect_frame(1);
        h0 = hs; d0 = drops;
        send_frame(0, N/4);
        send_frame(1, N/4);
        send_frame(2, N/4);
        idle;
        repeat (4) @(negedge clk);
        chk("t4_drops", drops - d0, 1);
        chk("t4_valid", out_valid, 1);
        chk("t4_held", hs - h0, 0);
        ready_mode = 1;
        wait_drain(2000);
        chk("t4_count", hs - h0, 2*N);

        // mid-frame resync at beat 10
        fill(0, 1); fill(1, 1);
        expect_frame(1);
        h0 = hs; s0 = serrs; d0 = drops;
        send_frame(0, 10);
        send_frame(1, N/4);
        idle;
        wait_drain(1000);
        chk("t5_serr", serrs - s0, 1);
        chk("t5_count", hs - h0, N);
        chk("t5_drops", drops - d0, 0);

        // reset in the middle of a read
        fill(0, 1);
        expect_frame(0);
        h0 = hs;
        send_frame(0, N/4);
        idle;
        n = 0;
        while (hs - h0 < 50 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("t6_reach50", n < 1000, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        hs = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_valid", out_valid, 0);
        chk("t6_index", out_index, 0);
        fill(1, 1);
        expect_frame(1);
        send_frame(1, N/4);
        idle;
        wait_drain(1000);
        chk("t6_count", hs, N);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fft_out_reorder.md
Name: fft_out_reorder

Overview:
- Collector on the output side of the 4-lane parallel FFT core (N=128).
- Each clock it accepts one beat of four complex results, which arrive in bit-reversed bin order, and writes them into a ping-pong frame buffer.
- It streams each completed frame out as one complex sample per handshake, in natural bin order 0..N-1.
- It feeds the serial downstream datapath and the output checker.

Parameters:
- NBITS_out, 10: bits per real/imag part; a complex word is 2*NBITS_out, with real in the upper half and imag in the lower half.
- N, 128: FFT frame length, a power of 2 and at least 8.
- LOG2N, 7: log2(N).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input beat valid; no back-pressure on the input side
- in_sof  in  1  qualifies the first beat of a frame; ignored when in_valid=0
- fftOut0_up  in  2*NBITS_out  lane 0
- fftOut0_down  in  2*NBITS_out  lane 1
- fftOut1_up  in  2*NBITS_out  lane 2
- fftOut1_down  in  2*NBITS_out  lane 3
- out_data  out  2*NBITS_out  natural-order complex sample
- out_index  out  LOG2N  bin number of out_data
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accept
- out_last  out  1  high with bin N-1
- frame_drop  out  1  one-cycle pulse: an incoming frame was discarded
- sync_err  out  1  one-cycle pulse: in_sof arrived mid-frame

Behaviour:
- Storage: 2 banks x N words of 2*NBITS_out. Each bank has a full flag. wr_bank and rd_bank are 1-bit pointers.
- Mapping: beat counter b runs 0..N/4-1. Lane l (0..3, order as in Ports) of beat b is written to address bitrev_LOG2N(4*b+l).
- Write FSM, W_IDLE:
  - in_valid & in_sof & !full[wr_bank] -> write beat 0, b=1, go to W_FILL.
  - in_valid & in_sof & full[wr_bank] -> pulse frame_drop, go to W_DROP.
- Write FSM, W_FILL:
  - Each in_valid beat is written and b is incremented. Gaps (in_valid=0) hold state.
  - When beat N/4-1 is written: full[wr_bank] is set, wr_bank toggles, go to W_IDLE.
- Write FSM, W_DROP: counts and discards N/4 beats, then returns to W_IDLE. Beats are counted including beat 0.
- in_sof during W_FILL with b!=0:
  - Pulse sync_err and discard the partial frame.
  - The bank is not marked full.
  - Treat the beat as beat 0 of a new frame in the same bank, so b becomes 1.
- in_sof during W_DROP: pulse sync_err and restart the drop count.
- in_valid without in_sof in W_IDLE: ignored, no flag.
- Read side:
  - out_valid = full[rd_bank].
  - out_data = bank[rd_bank][rd_idx], a combinational read of registered storage.
  - out_index = rd_idx.
  - out_last = out_valid & (rd_idx==N-1).
- Read handshake: on out_valid & out_ready, rd_idx increments. When rd_idx==N-1: rd_idx wraps to 0, full[rd_bank] clears, rd_bank toggles.
- Holding: out_data and out_index stay stable while out_valid & !out_ready.
- Latency: with the last beat written at edge t, out_valid is high after edge t, so index 0 is presentable in the cycle after the last input beat.
- Simultaneous set/clear: full is set by the writer and cleared by the reader only on different banks by construction. If both events happen on the same edge, both take effect.
- Throughput: with out_ready held high, one frame takes N read cycles versus N/4 write cycles. Sustained input faster than 1 frame per N cycles produces frame_drop; frames that are already buffered are never corrupted.
- Reset:
  - full[1:0]=0, wr_bank=rd_bank=0, rd_idx=0, b=0, write FSM=W_IDLE.
  - out_valid=0, out_last=0, frame_drop=0, sync_err=0. out_index=0. out_data is don't-care while out_valid=0.
  - Reset mid-frame or mid-read discards all buffered data; out_valid is 0 after the reset edge.

Test Plan:
- Single frame, out_ready=1. Beat b lane l real=4b+l, imag=0. Expect out_index 0..127 in order, with out_data real = bitrev7(index): index 0 -> 0, 1 -> 64, 2 -> 32, 127 -> 127. out_last only at index 127. First out_valid is 1 cycle after the last beat.
- Back-pressure: same frame with out_ready toggled pseudo-randomly (50%). Expect an identical output sequence, out_data and out_index stable during stalls, and exactly 128 handshakes.
- Ping-pong: two frames back-to-back (64 consecutive beats), frame B data = frame A data + 200. Expect 256 outputs: all of A, then all of B with no gap, and no frame_drop.
- Overflow: three frames back-to-back with out_ready=0. Expect a frame_drop pulse at frame C's sof. After out_ready goes to 1, expect only A then B to be output.
- Mid-frame resync: in_sof reasserted at beat 10 of a frame, followed by a full 32-beat frame. Expect one sync_err pulse, then exactly one valid 128-sample frame matching the second frame.
- Reset while out_index=50: expect out_valid=0 after the reset edge. A new frame afterwards is output from index 0 correctly.
